// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register. Fetches over a
// req/ready handshake and honours hazard stalls and ID-resolved redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_next_pc,
  output logic [31:0] o_instruction,
  output logic        o_valid
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_hold;
  logic [31:0] w_hold_nxt;
  logic [31:0] r_drain_addr;
  logic [31:0] w_drain_addr_nxt;
  ifid_t       r_ifid;
  ifid_t       w_ifid_nxt;
  ifid_t       w_bubble;
  ifid_t       w_fetched;
  ifid_t       w_released;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_redirect_pc = i_redirect_pc & ~32'h0000_0003;

  // A bubble keeps the old PC fields so only valid/instr change downstream.
  assign w_bubble   = '{pc: r_ifid.pc, next_pc: r_ifid.next_pc, instr: NOP_INSTR, valid: 1'b0};
  assign w_fetched  = '{pc: r_pc, next_pc: w_pc_plus4, instr: i_imem_rdata, valid: 1'b1};
  assign w_released = '{pc: r_pc, next_pc: w_pc_plus4, instr: r_hold, valid: 1'b1};

  // ---------------------------------------------------------------- state register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_FETCH: begin
        if (i_redirect) begin
          w_state_nxt = i_imem_ready ? ST_FETCH : ST_DRAIN;
        end else if (i_imem_ready && i_stall) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_redirect || !i_stall) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // A newer redirect keeps us draining; the new target waits in r_pc.
        if (!i_redirect && i_imem_ready) begin
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    o_imem_req  = 1'b0;
    o_imem_addr = r_pc;
    unique case (r_state)
      ST_FETCH: o_imem_req = 1'b1;
      ST_DRAIN: begin
        o_imem_req  = 1'b1;
        o_imem_addr = r_drain_addr;
      end
      default: o_imem_req = 1'b0;
    endcase
    // The request is gated directly by the reset pin so it drops immediately,
    // not just once the state register has been cleared.
    if (!reset) begin
      o_imem_req = 1'b0;
    end
  end

  assign o_pc          = r_ifid.pc;
  assign o_next_pc     = r_ifid.next_pc;
  assign o_instruction = r_ifid.instr;
  assign o_valid       = r_ifid.valid;

  // ---------------------------------------------------------------- datapath next values
  always_comb begin
    w_pc_nxt         = r_pc;
    w_hold_nxt       = r_hold;
    w_drain_addr_nxt = r_drain_addr;
    w_ifid_nxt       = r_ifid;

    if (i_redirect) begin
      w_ifid_nxt = w_bubble;
      w_pc_nxt   = w_redirect_pc;
      if (r_state == ST_FETCH && !i_imem_ready) begin
        w_drain_addr_nxt = r_pc;
      end
    end else begin
      unique case (r_state)
        ST_FETCH: begin
          if (i_imem_ready && !i_stall) begin
            w_ifid_nxt = w_fetched;
            w_pc_nxt   = w_pc_plus4;
          end else if (i_imem_ready) begin
            w_hold_nxt = i_imem_rdata;
          end else if (!i_stall) begin
            w_ifid_nxt = w_bubble;
          end
        end
        ST_HOLD: begin
          if (!i_stall) begin
            w_ifid_nxt = w_released;
            w_pc_nxt   = w_pc_plus4;
          end
        end
        ST_DRAIN: w_ifid_nxt = w_bubble;
        default:  w_ifid_nxt = w_bubble;
      endcase
    end
  end

  // ---------------------------------------------------------------- datapath registers
  // NOTE: the hold buffer and drain address are reset too; they are only read
  // after being written, but a known value keeps simulation free of X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc         <= RESET_PC;
      r_hold       <= NOP_INSTR;
      r_drain_addr <= RESET_PC;
      r_ifid       <= '{pc: 32'd0, next_pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      r_pc         <= w_pc_nxt;
      r_hold       <= w_hold_nxt;
      r_drain_addr <= w_drain_addr_nxt;
      r_ifid       <= w_ifid_nxt;
    end
  end

endmodule
